// File: rtl/rr_arb_mux_2x1_if.sv
// Handshake bundle for the 2:1 round-robin arbiter/mux: two source streams and one output stream.
interface rr_arb_mux_2x1_if #(
  parameter int unsigned WIDTH = 8
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             x_valid;
  logic [WIDTH-1:0] x_data;
  logic             x_ready;
  logic             sel;

  // Arbiter side: consumes both sources, produces the output stream.
  modport master (
    input  a_valid, a_data, b_valid, b_data, x_ready,
    output a_ready, b_ready, x_valid, x_data, sel
  );

  // Environment side: drives both sources, consumes the output stream.
  modport slave (
    output a_valid, a_data, b_valid, b_data, x_ready,
    input  a_ready, b_ready, x_valid, x_data, sel
  );
endinterface

// File: rtl/rr_arb_mux_2x1.sv
// Round-robin arbiter steering two valid/ready sources into one registered output stream.
module rr_arb_mux_2x1 #(
  parameter int unsigned WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  rr_arb_mux_2x1_if.master  bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] data_q;
  logic             sel_q;
  logic             last_grant_q;
  logic             load_en;
  logic             grant_a;
  logic             grant_b;

  // Output state register; reset drops any held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant selection and next-state: load when empty or draining; on contention favour the source not granted last.
  always_comb begin
    state_d = state_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
    load_en = (state_q == EMPTY) || bus.x_ready;
    if (load_en && !rst) begin
      grant_a = bus.a_valid && (!bus.b_valid || last_grant_q);
      grant_b = bus.b_valid && (!bus.a_valid || !last_grant_q);
    end
    if (grant_a || grant_b) begin
      state_d = FULL;
    end else if ((state_q == FULL) && bus.x_ready) begin
      state_d = EMPTY;
    end
  end

  // Capture the granted word, its source index and the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q       <= '0;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (grant_a || grant_b) begin
      data_q       <= grant_b ? bus.b_data : bus.a_data;
      sel_q        <= grant_b;
      last_grant_q <= grant_b;
    end
  end

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;
  assign bus.x_valid = (state_q == FULL);
  assign bus.x_data  = data_q;
  assign bus.sel     = sel_q;

endmodule

// File: tb/tb_rr_arb_mux_2x1.sv
// Directed and randomized bench for rr_arb_mux_2x1 against a transaction-level reference model.
module tb_rr_arb_mux_2x1;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  // Reference model: holding slot, its source, and which source should win the next tie.
  logic       m_full;
  logic [7:0] m_data;
  logic       m_sel;
  logic       m_prefer_b;
  logic       e_ga;
  logic       e_gb;

  rr_arb_mux_2x1_if #(.WIDTH(8)) bus ();

  rr_arb_mux_2x1 #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: drive inputs at negedge, check ready before the edge, check outputs after it.
  task automatic step(input logic r, input logic av, input logic [7:0] ad,
                      input logic bv, input logic [7:0] bd, input logic xr);
    logic can_take;
    @(negedge clk);
    rst         = r;
    bus.a_valid = av;
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_data  = bd;
    bus.x_ready = xr;
    #1;
    can_take = !r && (!m_full || xr);
    e_ga = 1'b0;
    e_gb = 1'b0;
    if (can_take) begin
      if (av && bv) begin
        e_gb = m_prefer_b;
        e_ga = !m_prefer_b;
      end else begin
        e_ga = av;
        e_gb = bv;
      end
    end
    check("a_ready", 32'(bus.a_ready), 32'(e_ga));
    check("b_ready", 32'(bus.b_ready), 32'(e_gb));
    @(posedge clk);
    if (r) begin
      m_full     = 1'b0;
      m_data     = 8'h00;
      m_sel      = 1'b0;
      m_prefer_b = 1'b0;
    end else if (e_ga || e_gb) begin
      m_full     = 1'b1;
      m_data     = e_gb ? bd : ad;
      m_sel      = e_gb;
      m_prefer_b = !e_gb;
    end else if (m_full && xr) begin
      m_full = 1'b0;
    end
    #1;
    check("x_valid", 32'(bus.x_valid), 32'(m_full));
    check("x_data",  32'(bus.x_data),  32'(m_data));
    check("sel",     32'(bus.sel),     32'(m_sel));
  endtask

  initial begin
    int na;
    int nb;
    n_pass      = 0;
    n_total     = 0;
    rst         = 1'b1;
    bus.a_valid = 1'b0;
    bus.a_data  = 8'h00;
    bus.b_valid = 1'b0;
    bus.b_data  = 8'h00;
    bus.x_ready = 1'b0;
    m_full      = 1'b0;
    m_data      = 8'h00;
    m_sel       = 1'b0;
    m_prefer_b  = 1'b0;
    e_ga        = 1'b0;
    e_gb        = 1'b0;

    // Reset with both sources asserting valid.
    step(1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
    step(1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
    check("rst_x_valid", 32'(bus.x_valid), 32'h0);
    check("rst_x_data",  32'(bus.x_data),  32'h0);

    // Single source a.
    step(1'b0, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b1);
    check("single_a_data", 32'(bus.x_data), 32'h3C);
    check("single_a_sel",  32'(bus.sel),    32'h0);

    // Contention from reset: strict alternation starting with a, one word per cycle.
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    na = 0;
    nb = 0;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 8'(8'hA0 + na), 1'b1, 8'(8'hB0 + nb), 1'b1);
      if (e_ga) na++;
      if (e_gb) nb++;
      check("cont_data", 32'(bus.x_data),
            (k % 2 == 0) ? 32'(8'hA0 + k / 2) : 32'(8'hB0 + k / 2));
      check("cont_sel",   32'(bus.sel),     32'(k % 2));
      check("cont_valid", 32'(bus.x_valid), 32'h1);
    end

    // Backpressure: hold 55 from b while a keeps requesting.
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 8'h55, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
      check("bp_data", 32'(bus.x_data), 32'h55);
      check("bp_sel",  32'(bus.sel),    32'h1);
    end
    step(1'b0, 1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
    check("bp_release_valid", 32'(bus.x_valid), 32'h1);
    check("bp_release_data",  32'(bus.x_data),  32'h77);

    // Drain to empty, then lone b is granted.
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check("drain_valid", 32'(bus.x_valid), 32'h0);
    check("drain_data",  32'(bus.x_data),  32'h77);
    step(1'b0, 1'b0, 8'h00, 1'b1, 8'h99, 1'b1);
    check("lone_b_sel", 32'(bus.sel), 32'h1);

    // Reset while full; afterwards contention grants a first.
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("midrst_valid", 32'(bus.x_valid), 32'h0);
    step(1'b0, 1'b1, 8'hC1, 1'b1, 8'hD1, 1'b1);
    check("post_rst_data", 32'(bus.x_data), 32'hC1);
    check("post_rst_sel",  32'(bus.sel),    32'h0);

    // Random traffic with occasional reset.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 31) == 0), 1'($urandom), 8'($urandom),
           1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
